pc_result_tx: RTL and testbench

Return-path transmitter for the PC link: on a report request it snapshots the test result counters (error count plus four 32-bit latency/throughput statistics) and streams them to the PC as a framed byte sequence over a valid/ready byte interface. It is the PC-bound counterpart of the command parser's inbound byte path. It sits beside the test FSM and result analyzer, and is triggered by test completion or a PC status query.

---
 rtl/pc_link_pkg.sv | 41 ++++
 rtl/pc_result_tx_if.sv | 11 +
 rtl/pc_stall_timer.sv | 25 ++
 rtl/pc_result_tx.sv | 121 ++++++++++++
 tb/tb_pc_result_tx.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/pc_link_pkg.sv
// Shared PC-link definitions: frame constants, response FSM states and the
// result snapshot layout used by the return-path transmitter.
package pc_link_pkg;

   localparam int unsigned BYTE_W          = 8;
   localparam int unsigned ERR_W           = 16;
   localparam int unsigned STAT_W          = 32;
   localparam int unsigned RSP_PAYLOAD_LEN = 18;
   localparam int unsigned RSP_FRAME_LEN   = 21;
   localparam int unsigned IDX_W           = 5;
   localparam int unsigned SNAP_W          = ERR_W + 4 * STAT_W;

   localparam logic [BYTE_W-1:0] SYNC_BYTE_DEFAULT = 8'hA5;
   localparam logic [BYTE_W-1:0] RSP_LEN_BYTE      = 8'h12;

   typedef enum logic [2:0] {
      RSP_IDLE    = 3'd0,
      RSP_HDR     = 3'd1,
      RSP_LEN     = 3'd2,
      RSP_PAYLOAD = 3'd3,
      RSP_CHK     = 3'd4
   } rsp_state_t;

   // Field order is the on-wire order; the first field lands in the top bits.
   typedef struct packed {
      logic [ERR_W-1:0]  error_count;
      logic [STAT_W-1:0] min_latency;
      logic [STAT_W-1:0] max_latency;
      logic [STAT_W-1:0] average_latency;
      logic [STAT_W-1:0] throughput;
   } rsp_snapshot_t;

   // Payload byte idx of the snapshot, MSB-first.
   function automatic logic [BYTE_W-1:0] snap_byte(input rsp_snapshot_t s,
                                                   input logic [IDX_W-1:0] idx);
      logic [SNAP_W-1:0] flat;
      flat = s;
      return BYTE_W'(flat >> (BYTE_W * (RSP_PAYLOAD_LEN - 1 - 32'(idx))));
   endfunction

endpackage

// File: rtl/pc_result_tx_if.sv
// Valid/ready byte stream toward the PC.
interface pc_result_tx_if;
   import pc_link_pkg::*;

   logic              pc_rsp_valid;
   logic [BYTE_W-1:0] pc_rsp_data;
   logic              pc_rsp_ready;

   modport master (output pc_rsp_valid, output pc_rsp_data, input pc_rsp_ready);
   modport slave  (input  pc_rsp_valid, input  pc_rsp_data, output pc_rsp_ready);
endinterface

// File: rtl/pc_stall_timer.sv
// Counts consecutive stall cycles; expired_c fires during stall cycle LIMIT.
// LIMIT of 0 disables expiry.
module pc_stall_timer #(
   parameter int unsigned LIMIT = 65535
) (
   input  logic clk,
   input  logic rst,
   input  logic stall,
   input  logic clear,
   output logic expired_c
);

   localparam int unsigned CNT_W = (LIMIT > 2) ? $clog2(LIMIT) : 1;
   localparam int unsigned LAST  = (LIMIT == 0) ? 0 : LIMIT - 1;

   logic [CNT_W-1:0] count;

   assign expired_c = (LIMIT != 0) && stall && (count == CNT_W'(LAST));

   always_ff @(posedge clk) begin
      if (rst || clear || expired_c) count <= '0;
      else if (stall)                count <= count + CNT_W'(1);
   end

endmodule

// File: rtl/pc_result_tx.sv
// Return-path transmitter: snapshots the result counters on request and
// streams a SYNC/LEN/payload/CHK frame to the PC over a valid/ready byte link.
module pc_result_tx
   import pc_link_pkg::*;
#(
   parameter logic [BYTE_W-1:0] SYNC_BYTE      = SYNC_BYTE_DEFAULT,
   parameter int unsigned       TIMEOUT_CYCLES = 65535
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              report_start,
   input  logic [ERR_W-1:0]  error_count,
   input  logic [STAT_W-1:0] min_latency,
   input  logic [STAT_W-1:0] max_latency,
   input  logic [STAT_W-1:0] average_latency,
   input  logic [STAT_W-1:0] throughput,
   pc_result_tx_if.master    pc_rsp,
   output logic              busy,
   output logic              frame_done,
   output logic              report_dropped,
   output logic              tx_timeout
);

   rsp_state_t        state, state_nxt;
   rsp_snapshot_t     snap, snap_nxt;
   logic [IDX_W-1:0]  idx, idx_nxt;
   logic [BYTE_W-1:0] chk, chk_nxt;
   logic [BYTE_W-1:0] data_nxt;
   logic              valid_nxt, busy_nxt, done_nxt, dropped_nxt, timeout_nxt;
   logic              hs_c, stall_c, expired_c, accept_c;

   assign hs_c     = pc_rsp.pc_rsp_valid & pc_rsp.pc_rsp_ready;
   assign stall_c  = pc_rsp.pc_rsp_valid & ~pc_rsp.pc_rsp_ready;
   assign accept_c = report_start && (state == RSP_IDLE);

   pc_stall_timer #(.LIMIT(TIMEOUT_CYCLES)) u_stall_timer (
      .clk       (clk),
      .rst       (rst),
      .stall     (stall_c),
      .clear     (hs_c),
      .expired_c (expired_c)
   );

   always_ff @(posedge clk) begin
      if (rst) state <= RSP_IDLE;
      else     state <= state_nxt;
   end

   // Advance only on a handshake; a stall timeout overrides everything.
   always_comb begin
      state_nxt = state;
      if (expired_c) begin
         state_nxt = RSP_IDLE;
      end else begin
         case (state)
            RSP_IDLE:    if (report_start) state_nxt = RSP_HDR;
            RSP_HDR:     if (hs_c)         state_nxt = RSP_LEN;
            RSP_LEN:     if (hs_c)         state_nxt = RSP_PAYLOAD;
            RSP_PAYLOAD: if (hs_c && idx == IDX_W'(RSP_PAYLOAD_LEN - 1))
                                           state_nxt = RSP_CHK;
            RSP_CHK:     if (hs_c)         state_nxt = RSP_IDLE;
            default:                       state_nxt = RSP_IDLE;
         endcase
      end
   end

   // Next values of the datapath and of every registered output.
   always_comb begin
      snap_nxt    = snap;
      idx_nxt     = idx;
      chk_nxt     = chk;
      data_nxt    = '0;
      valid_nxt   = (state_nxt != RSP_IDLE);
      busy_nxt    = (state_nxt != RSP_IDLE);
      done_nxt    = hs_c && (state == RSP_CHK);
      dropped_nxt = report_start && (state != RSP_IDLE);
      timeout_nxt = expired_c;

      if (accept_c) begin
         snap_nxt = '{error_count, min_latency, max_latency, average_latency, throughput};
         idx_nxt  = '0;
         chk_nxt  = '0;
      end
      if (hs_c && state == RSP_PAYLOAD) idx_nxt = idx + IDX_W'(1);
      if (hs_c && (state == RSP_LEN || state == RSP_PAYLOAD))
         chk_nxt = chk + pc_rsp.pc_rsp_data;

      case (state_nxt)
         RSP_HDR:     data_nxt = SYNC_BYTE;
         RSP_LEN:     data_nxt = RSP_LEN_BYTE;
         RSP_PAYLOAD: data_nxt = snap_byte(snap_nxt, idx_nxt);
         RSP_CHK:     data_nxt = BYTE_W'(8'd0 - chk_nxt);
         default:     data_nxt = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         snap                <= '0;
         idx                 <= '0;
         chk                 <= '0;
         pc_rsp.pc_rsp_valid <= 1'b0;
         pc_rsp.pc_rsp_data  <= '0;
         busy                <= 1'b0;
         frame_done          <= 1'b0;
         report_dropped      <= 1'b0;
         tx_timeout          <= 1'b0;
      end else begin
         snap                <= snap_nxt;
         idx                 <= idx_nxt;
         chk                 <= chk_nxt;
         pc_rsp.pc_rsp_valid <= valid_nxt;
         pc_rsp.pc_rsp_data  <= data_nxt;
         busy                <= busy_nxt;
         frame_done          <= done_nxt;
         report_dropped      <= dropped_nxt;
         tx_timeout          <= timeout_nxt;
      end
   end

endmodule

// File: tb/tb_pc_result_tx.sv
// Bench for pc_result_tx: table vectors, corner sequences and random frames
// compared against a byte-list frame model.
module tb_pc_result_tx;
   import pc_link_pkg::*;

   localparam int unsigned TO     = 8;
   localparam int          BUDGET = 200;

   typedef struct {
      logic [15:0] e;
      logic [31:0] mn, mx, av, th;
   } frame_in_t;

   typedef struct {
      frame_in_t  in;
      int         mode;
      int         drop_at;
      bit         corrupt;
      logic [7:0] exp_chk;
      int         exp_done_at;
      int         exp_drops;
   } vec_t;

   logic        clk = 1'b0, rst = 1'b1, report_start = 1'b0, ready = 1'b0;
   logic [15:0] error_count = '0;
   logic [31:0] min_latency = '0, max_latency = '0, average_latency = '0, throughput = '0;
   logic        busy, frame_done, report_dropped, tx_timeout;

   pc_result_tx_if rsp_if ();
   assign rsp_if.pc_rsp_ready = ready;

   pc_result_tx #(.SYNC_BYTE(8'hA5), .TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .rst(rst), .report_start(report_start),
      .error_count(error_count), .min_latency(min_latency), .max_latency(max_latency),
      .average_latency(average_latency), .throughput(throughput),
      .pc_rsp(rsp_if), .busy(busy), .frame_done(frame_done),
      .report_dropped(report_dropped), .tx_timeout(tx_timeout)
   );

   always #5 clk = ~clk;

   int n_checks = 0, n_pass = 0;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, got, exp);
   endtask

   // Monitor: collect accepted bytes, flag data changes or valid drops during a stall.
   logic [7:0] rx_q[$];
   int         stab_err = 0;
   logic       prev_stall = 1'b0;
   logic [7:0] prev_data = '0;
   always @(negedge clk) begin
      if (rsp_if.pc_rsp_valid && ready) rx_q.push_back(rsp_if.pc_rsp_data);
      if (prev_stall) begin
         if (!rsp_if.pc_rsp_valid) begin
            if (!(tx_timeout || rst)) stab_err++;
         end else if (rsp_if.pc_rsp_data != prev_data) stab_err++;
      end
      prev_stall = rsp_if.pc_rsp_valid && !ready;
      prev_data  = rsp_if.pc_rsp_data;
   end

   // Reference frame: fields listed with byte counts, MSB-first, 8-bit zero-sum checksum.
   function automatic void model_frame(input frame_in_t v, output logic [7:0] q[$]);
      logic [31:0] fields[5];
      int          nbytes[5];
      int          sum;
      logic [7:0]  b;
      fields = '{{16'h0, v.e}, v.mn, v.mx, v.av, v.th};
      nbytes = '{2, 4, 4, 4, 4};
      q = {};
      q.push_back(8'hA5);
      q.push_back(8'h12);
      sum = 18;
      for (int f = 0; f < 5; f++)
         for (int k = nbytes[f] - 1; k >= 0; k--) begin
            b = 8'((fields[f] >> (8 * k)) & 32'hFF);
            q.push_back(b);
            sum += int'(b);
         end
      q.push_back(8'((256 - sum % 256) % 256));
   endfunction

   task automatic check_frame(input string name, input frame_in_t v);
      logic [7:0] exp[$];
      int bad;
      model_frame(v, exp);
      bad = -1;
      for (int i = 0; i < exp.size(); i++)
         if (bad < 0 && (i >= rx_q.size() || rx_q[i] !== exp[i])) bad = i;
      if (bad < 0 && rx_q.size() != exp.size()) bad = exp.size();
      n_checks++;
      if (bad < 0) n_pass++;
      else $display("FAIL %s: byte %0d got %02h expected %02h (got %0d bytes, need %0d)", name, bad,
                    (bad < rx_q.size()) ? rx_q[bad] : 8'hxx, (bad < exp.size()) ? exp[bad] : 8'hxx,
                    rx_q.size(), exp.size());
   endtask

   int          r_done_at, r_drops, r_to_at;
   logic [9:0]  r_first;
   logic [1:0]  r_end;
   logic [12:0] r_rst_out;

   // Start (unless already sampled), then run until done, timeout, reset or budget.
   // Iteration k drives inputs seen in cycle N+k and samples outputs of cycle N+k.
   task automatic run_frame(input frame_in_t v, input int mode, input int drop_at, input bit corrupt,
                            input int reset_at, input bit skip_start);
      int low_run = 0;
      bit rdy;
      r_done_at = -1; r_drops = 0; r_to_at = -1; r_first = '0; r_end = 2'b11; r_rst_out = '1;
      rx_q.delete();
      if (!skip_start) begin
         @(posedge clk); #1;
         error_count = v.e; min_latency = v.mn; max_latency = v.mx;
         average_latency = v.av; throughput = v.th;
         report_start = 1'b1;
      end
      for (int k = 1; k <= BUDGET; k++) begin
         @(posedge clk); #1;
         report_start = (k == drop_at);
         rst = (k == reset_at);
         if (corrupt) begin
            error_count = '1; min_latency = '1; max_latency = '1; average_latency = '1; throughput = '1;
         end
         case (mode)
            1:       rdy = (k % 3 == 0);
            2:       begin rdy = ($urandom_range(0, 2) != 0) || low_run >= 4; low_run = rdy ? 0 : low_run + 1; end
            3:       rdy = (k == 1);
            default: rdy = 1'b1;
         endcase
         ready = rdy;
         @(negedge clk);
         if (k == 1) r_first = {rsp_if.pc_rsp_valid, busy, rsp_if.pc_rsp_data};
         if (report_dropped) r_drops++;
         if (frame_done) begin r_done_at = k; r_end = {rsp_if.pc_rsp_valid, busy}; end
         if (tx_timeout) begin r_to_at = k; r_end = {rsp_if.pc_rsp_valid, busy}; end
         if (reset_at > 0 && k == reset_at + 1)
            r_rst_out = {rsp_if.pc_rsp_valid, rsp_if.pc_rsp_data, busy, frame_done, report_dropped, tx_timeout};
         if (r_done_at > 0 || r_to_at > 0 || (reset_at > 0 && k == reset_at + 1)) break;
      end
   endtask

   task automatic idle_check(input string name);
      int bad = 0;
      for (int k = 0; k < 4; k++) begin
         @(posedge clk); #1; ready = 1'b1; report_start = 1'b0;
         @(negedge clk);
         if (rsp_if.pc_rsp_valid || busy || frame_done) bad++;
      end
      check(name, 64'(bad), 64'd0);
   endtask

   vec_t      vecs[7];
   frame_in_t basic, zeros, ones, mixed, rv;
   int        s0, drop;

   initial begin
      basic = '{16'h0003, 32'd1, 32'h10, 32'd8, 32'h100};
      zeros = '{16'h0, 32'h0, 32'h0, 32'h0, 32'h0};
      ones  = '{16'hFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
      mixed = '{16'h1234, 32'h01020304, 32'hA0B0C0D0, 32'h0, 32'h80000000};
      //          inputs  mode drop corrupt chk    done drops
      vecs[0] = '{basic, 0,  0,  1'b0, 8'hD1, 22, 0};
      vecs[1] = '{basic, 1,  0,  1'b0, 8'hD1, -1, 0};
      vecs[2] = '{basic, 0,  0,  1'b1, 8'hD1, 22, 0};
      vecs[3] = '{basic, 0,  5,  1'b0, 8'hD1, 22, 1};
      vecs[4] = '{zeros, 0,  21, 1'b0, 8'hEE, 22, 1};
      vecs[5] = '{ones,  1,  0,  1'b0, 8'h00, -1, 0};
      vecs[6] = '{mixed, 2,  0,  1'b0, 8'h3E, -1, 0};

      repeat (2) @(posedge clk);
      @(negedge clk);
      check("reset_state", 64'({rsp_if.pc_rsp_valid, rsp_if.pc_rsp_data, busy, frame_done,
                                report_dropped, tx_timeout}), 64'd0);
      @(posedge clk); #1; rst = 1'b0;

      foreach (vecs[i]) begin
         s0 = stab_err;
         run_frame(vecs[i].in, vecs[i].mode, vecs[i].drop_at, vecs[i].corrupt, 0, 1'b0);
         check_frame($sformatf("v%0d_frame", i), vecs[i].in);
         check($sformatf("v%0d_chk", i), 64'((rx_q.size() > 0) ? rx_q[rx_q.size() - 1] : 8'hxx),
               64'(vecs[i].exp_chk));
         check($sformatf("v%0d_first", i), 64'(r_first), 64'({1'b1, 1'b1, 8'hA5}));
         if (vecs[i].exp_done_at >= 0)
            check($sformatf("v%0d_done_at", i), 64'(r_done_at), 64'(vecs[i].exp_done_at));
         else
            check($sformatf("v%0d_done_seen", i), 64'(r_done_at > 0), 64'd1);
         check($sformatf("v%0d_end_idle", i), 64'(r_end), 64'd0);
         check($sformatf("v%0d_drops", i), 64'(r_drops), 64'(vecs[i].exp_drops));
         check($sformatf("v%0d_timeout", i), 64'(r_to_at), 64'hFFFF_FFFF_FFFF_FFFF);
         check($sformatf("v%0d_stable", i), 64'(stab_err - s0), 64'd0);
         idle_check($sformatf("v%0d_no_extra_frame", i));
      end

      // Back-to-back: start in the frame_done cycle is accepted, 1-cycle gap.
      run_frame(mixed, 0, 22, 1'b0, 0, 1'b0);
      check("b2b_done_at", 64'(r_done_at), 64'd22);
      check_frame("b2b_frame1", mixed);
      run_frame(mixed, 0, 0, 1'b0, 0, 1'b1);
      check("b2b_first", 64'(r_first), 64'({1'b1, 1'b1, 8'hA5}));
      check("b2b_drops", 64'(r_drops), 64'd0);
      check_frame("b2b_frame2", mixed);
      idle_check("b2b_idle");

      // Timeout: HDR accepted, then ready held low.
      run_frame(basic, 3, 0, 1'b0, 0, 1'b0);
      check("to_at", 64'(r_to_at), 64'(2 + TO));
      check("to_no_done", 64'(r_done_at), 64'hFFFF_FFFF_FFFF_FFFF);
      check("to_end_state", 64'(r_end), 64'd0);
      check("to_bytes", 64'({rx_q.size() == 1, (rx_q.size() > 0) ? rx_q[0] : 8'h00}), 64'({1'b1, 8'hA5}));
      idle_check("to_idle");
      run_frame(basic, 0, 0, 1'b0, 0, 1'b0);
      check_frame("to_recover_frame", basic);
      check("to_recover_done", 64'(r_done_at), 64'd22);

      // Reset mid-payload.
      run_frame(mixed, 0, 0, 1'b0, 8, 1'b0);
      check("rst_outputs", 64'(r_rst_out), 64'd0);
      check("rst_no_done", 64'(r_done_at), 64'hFFFF_FFFF_FFFF_FFFF);
      idle_check("rst_idle");
      run_frame(basic, 0, 0, 1'b0, 0, 1'b0);
      check("rst_recover_first", 64'(r_first), 64'({1'b1, 1'b1, 8'hA5}));
      check_frame("rst_recover_frame", basic);

      // Random frames with random backpressure and optional busy start.
      for (int t = 0; t < 12; t++) begin
         rv = '{16'($urandom), $urandom, $urandom, $urandom, $urandom};
         drop = ($urandom_range(0, 1) != 0) ? int'($urandom_range(2, 20)) : 0;
         s0 = stab_err;
         run_frame(rv, 2, drop, 1'b0, 0, 1'b0);
         check_frame($sformatf("rnd%0d_frame", t), rv);
         check($sformatf("rnd%0d_done", t), 64'(r_done_at > 0), 64'd1);
         check($sformatf("rnd%0d_drops", t), 64'(r_drops), 64'((drop > 0) ? 1 : 0));
         check($sformatf("rnd%0d_stable", t), 64'(stab_err - s0), 64'd0);
         idle_check($sformatf("rnd%0d_idle", t));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
